// File: rtl/gate_response_checker.sv
// Checks settled responses of the seven basic two-input gates against a/b,
// counting vectors and failures per run and capturing the first failure.
module gate_response_checker #(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             not_in,
  input  logic             nand_in,
  input  logic             nor_in,
  input  logic             xor_in,
  input  logic             xnor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] vec_count,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_seen,
  output logic [1:0]       first_fail_ab,
  output logic [6:0]       first_fail_mask
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_CHECK = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  localparam logic [ERR_W-1:0] LP_LAST_VEC = ERR_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] LP_ERR_MAX  = '1;

  logic [1:0]       r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_vec_count;
  logic [ERR_W-1:0] r_err_count;
  logic             r_fail_seen;
  logic [1:0]       r_first_ab;
  logic [6:0]       r_first_mask;

  logic [1:0]       w_state_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_pass_nxt;
  logic [ERR_W-1:0] w_vec_nxt;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_fail_nxt;
  logic [1:0]       w_ab_nxt;
  logic [6:0]       w_mask_nxt;
  logic [6:0]       w_expected;
  logic [6:0]       w_observed;
  logic [6:0]       w_mismatch;

  // Mismatch bit order: AND, OR, NOT, NAND, NOR, XOR, XNOR from bit 0 up
  assign w_expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign w_observed = {xnor_in, xor_in, nor_in, nand_in, not_in, or_in, and_in};
  assign w_mismatch = w_expected ^ w_observed;

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec_count;
    w_err_nxt   = r_err_count;
    w_fail_nxt  = r_fail_seen;
    w_ab_nxt    = r_first_ab;
    w_mask_nxt  = r_first_mask;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_CHECK;
          w_vec_nxt   = '0;
          w_err_nxt   = '0;
          w_fail_nxt  = 1'b0;
          w_ab_nxt    = 2'b00;
          w_mask_nxt  = 7'b0;
        end
      end
      S_CHECK: begin
        if (vec_valid) begin
          w_vec_nxt = r_vec_count + ERR_W'(1);
          if (|w_mismatch) begin
            if (r_err_count != LP_ERR_MAX) begin
              w_err_nxt = r_err_count + ERR_W'(1);
            end
            if (!r_fail_seen) begin
              w_fail_nxt = 1'b1;
              w_ab_nxt   = {a, b};
              w_mask_nxt = w_mismatch;
            end
          end
          if (r_vec_count == LP_LAST_VEC) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Status flags track the state being entered so they align with it
    w_busy_nxt = (w_state_nxt == S_CHECK);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_vec_count  <= '0;
      r_err_count  <= '0;
      r_fail_seen  <= 1'b0;
      r_first_ab   <= 2'b00;
      r_first_mask <= 7'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_vec_count  <= w_vec_nxt;
      r_err_count  <= w_err_nxt;
      r_fail_seen  <= w_fail_nxt;
      r_first_ab   <= w_ab_nxt;
      r_first_mask <= w_mask_nxt;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign vec_count       = r_vec_count;
  assign err_count       = r_err_count;
  assign fail_seen       = r_fail_seen;
  assign first_fail_ab   = r_first_ab;
  assign first_fail_mask = r_first_mask;

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 The block SHALL have parameter NUM_VECTORS, default 4, number of vectors accepted per check run (legal range 1..255).
REQ-002 The block SHALL have parameter ERR_W, default 8, width of the error and vector counters.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, single-cycle pulse that begins a check run.
REQ-006 Port vec_valid, input, 1, marks the current a/b/response inputs as one settled vector to check.
REQ-007 Ports a, b, input, 1 each, stimulus operands that produced the response.
REQ-008 Ports and_in, or_in, not_in, nand_in, nor_in, xor_in, xnor_in, input, 1 each, gate responses under check.
REQ-009 Port busy, output, 1, high while in CHECK.
REQ-010 Port done, output, 1, high while in DONE.
REQ-011 Port pass, output, 1, high in DONE when err_count is zero.
REQ-012 Port vec_count, output, ERR_W, vectors accepted in the current run.
REQ-013 Port err_count, output, ERR_W, failing vectors in the current run.
REQ-014 Port fail_seen, output, 1, high once any vector in the run has failed.
REQ-015 Port first_fail_ab, output, 2, {a,b} of the first failing vector.
REQ-016 Port first_fail_mask, output, 7, mismatch bits of the first failing vector: bit0 AND, bit1 OR, bit2 NOT, bit3 NAND, bit4 NOR, bit5 XOR, bit6 XNOR.

Function
REQ-017 Expected values SHALL be AND=a&b, OR=a|b, NOT=~a, NAND=~(a&b), NOR=~(a|b), XOR=a^b, XNOR=~(a^b).
REQ-018 The FSM SHALL have states IDLE, CHECK, DONE.
REQ-019 IDLE->CHECK on start, and DONE->CHECK on start; both clear vec_count, err_count, fail_seen, first_fail_ab and first_fail_mask on that same edge.
REQ-020 In CHECK, start SHALL be ignored.
REQ-021 In CHECK, each cycle with vec_valid high SHALL be sampled on that clock edge: vec_count increments by 1, and if any mismatch bit is set, err_count increments by 1 (once per vector, not per bit).
REQ-022 On the first failing vector of a run, first_fail_ab and first_fail_mask SHALL be captured and fail_seen set; later failures SHALL NOT overwrite them.
REQ-023 The edge that accepts vector number NUM_VECTORS SHALL move the FSM to DONE; that vector's result is included in the counts.
REQ-024 vec_valid SHALL be ignored in IDLE and DONE; counts hold.
REQ-025 err_count SHALL saturate at 2^ERR_W-1; vec_count cannot exceed NUM_VECTORS.
REQ-026 Outputs SHALL be registered; busy, done and pass change on the edge of the state change, and counts are visible the cycle after sampling.
REQ-027 pass SHALL be 0 outside DONE.
REQ-028 A start pulse coinciding with vec_valid in IDLE/DONE SHALL start the run without sampling that vector.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, done=0, pass=0, fail_seen=0, vec_count=0, err_count=0, first_fail_ab=0, first_fail_mask=0, regardless of clk.
REQ-030 Reset asserted mid-run SHALL abandon the run; after release the block waits in IDLE for start.

Verification
REQ-031 start, then four correct vectors (00,01,10,11), one per cycle -> DONE after 4th edge, vec_count=4, err_count=0, pass=1, fail_seen=0.
REQ-032 Run with vector a=1,b=0 carrying xor_in=0 and nor_in=1 -> err_count=1, first_fail_ab=2'b10, first_fail_mask=7'b0110000, pass=0.
REQ-033 Two failing vectors (01 with and_in=1, then 11 with not_in=1) -> err_count=2, first_fail_ab=2'b01, first_fail_mask=7'b0000001.
REQ-034 vec_valid gaps of 3 idle cycles between vectors, plus vec_valid pulses before start -> only in-run vectors counted, vec_count=4.
REQ-035 rst_n pulsed low between clock edges after 2 vectors -> outputs zero immediately; new start gives a clean run with pass=1.
REQ-036 start from DONE with a failed prior run -> counts and capture cleared on that edge, busy=1, done=0.
